// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage with PC ownership, in-order memory requests,
// a small {pc, word} buffer toward IF/ID, stall hold and redirect squash.
//
// Ports:
//   clk, rstn         clock, synchronous active-low reset
//   imem_req_valid    request valid toward instruction memory
//   imem_req_ready    memory accepts the request this cycle
//   imem_addr         word-aligned request address
//   imem_rsp_valid    in-order response word valid
//   imem_rsp_data     response instruction word
//   redirect          taken branch/jump: squash and refetch from redirect_pc
//   redirect_pc       new fetch target
//   stall             IF/ID cannot accept this cycle
//   ins_valid         ins/pc_out valid
//   ins               instruction to IF/ID (NOP when nothing buffered)
//   pc_out            PC of ins (holds its last value when nothing buffered)
//   misalign          (IF_MISALIGN_TRAP_EN only) sticky misaligned-redirect trap
//
// Optional feature macro: IF_MISALIGN_TRAP_EN. When undefined, the low two bits
// of redirect_pc are masked and fetch continues at the aligned address.
module if_fetch #(
    parameter int                  WordSize    = 32,
    parameter logic [WordSize-1:0] ResetVector = '0,
    parameter int                  BufDepth    = 2
) (
    input  logic                clk,
    input  logic                rstn,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [WordSize-1:0] imem_addr,
    input  logic                imem_rsp_valid,
    input  logic [31:0]         imem_rsp_data,
    input  logic                redirect,
    input  logic [WordSize-1:0] redirect_pc,
    input  logic                stall,
    output logic                ins_valid,
    output logic [31:0]         ins,
    output logic [WordSize-1:0] pc_out
`ifdef IF_MISALIGN_TRAP_EN
    ,
    output logic                misalign
`endif
);
    localparam int PW = $clog2(BufDepth);
    localparam int CW = $clog2(BufDepth + 1);
    localparam logic [31:0] Nop = 32'h00000013;
    localparam logic [WordSize-1:0] AlignMask = {{(WordSize-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {FETCH, DRAIN, HALT} state_e;

    state_e              state_q, state_d;
    logic [WordSize-1:0] pc_q, pc_d;
    logic [WordSize-1:0] pc_out_q, pc_out_d;
    logic [CW-1:0]       outst_q, outst_d;
    logic [CW-1:0]       drop_q, drop_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PW-1:0]       rd_q, rd_d;
    logic [PW-1:0]       wr_q, wr_d;
    logic [PW-1:0]       al_q, al_d;
    logic [31:0]         buf_ins_q [BufDepth];
    logic [31:0]         buf_ins_d [BufDepth];
    logic [WordSize-1:0] buf_pc_q  [BufDepth];
    logic [WordSize-1:0] buf_pc_d  [BufDepth];
`ifdef IF_MISALIGN_TRAP_EN
    logic                misalign_q, misalign_d;
`endif

    logic room, req_valid, acc, rsp, pop;

    assign ins_valid      = cnt_q != '0;
    assign ins            = ins_valid ? buf_ins_q[rd_q] : Nop;
    assign pc_out         = ins_valid ? buf_pc_q[rd_q] : pc_out_q;
    assign imem_req_valid = req_valid;
    assign imem_addr      = pc_q & AlignMask;
`ifdef IF_MISALIGN_TRAP_EN
    assign misalign       = misalign_q;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pc_out_d  = ins_valid ? buf_pc_q[rd_q] : pc_out_q;
        drop_d    = drop_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        al_d      = al_q;
        buf_ins_d = buf_ins_q;
        buf_pc_d  = buf_pc_q;
`ifdef IF_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        room = ({1'b0, outst_q} + {1'b0, cnt_q}) < (CW + 1)'(BufDepth);
        // In DRAIN the refetch may go out in the same cycle the last stale response is dropped.
        req_valid = rstn && ((state_q == FETCH) ? room :
                             (state_q == DRAIN) ? (imem_rsp_valid && drop_q == CW'(1)) : 1'b0);
        acc     = req_valid && imem_req_ready;
        rsp     = imem_rsp_valid && outst_q != '0;
        pop     = ins_valid && !stall;
        outst_d = outst_q + CW'(acc) - CW'(rsp);
        if (acc)
            pc_d = pc_q + WordSize'(4);
        if (redirect && state_q != HALT) begin
            // Everything in flight after this cycle belongs to the squashed path.
            pc_d    = redirect_pc & AlignMask;
            drop_d  = outst_d;
            state_d = (outst_d != '0) ? DRAIN : FETCH;
            cnt_d   = '0;
            rd_d    = '0;
            wr_d    = '0;
            al_d    = '0;
`ifdef IF_MISALIGN_TRAP_EN
            if (redirect_pc[1:0] != 2'b00) begin
                state_d    = HALT;
                misalign_d = 1'b1;
            end
`endif
        end else if (state_q == FETCH) begin
            // Slots are reserved in request order; the PC is written at accept and
            // the word lands in the same slot when its response returns.
            if (acc) begin
                buf_pc_d[al_q] = pc_q;
                al_d           = al_q + PW'(1);
            end
            if (rsp) begin
                buf_ins_d[wr_q] = imem_rsp_data;
                wr_d            = wr_q + PW'(1);
            end
            if (pop)
                rd_d = rd_q + PW'(1);
            cnt_d = cnt_q + CW'(rsp) - CW'(pop);
        end else if (state_q == DRAIN) begin
            if (rsp)
                drop_d = drop_q - CW'(1);
            if (rsp && drop_q == CW'(1))
                state_d = FETCH;
            if (acc) begin
                buf_pc_d[al_q] = pc_q;
                al_d           = al_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= FETCH;
            pc_q     <= ResetVector;
            pc_out_q <= '0;
            outst_q  <= '0;
            drop_q   <= '0;
            cnt_q    <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
            al_q     <= '0;
`ifdef IF_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            al_q     <= al_d;
`ifdef IF_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    // Buffer storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        buf_ins_q <= buf_ins_d;
        buf_pc_q  <= buf_pc_d;
    end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed self-checking bench for if_fetch with a latency-configurable memory model.
`timescale 1ns/1ps
module tb_if_fetch;
    localparam int          BD  = 4;
    localparam logic [31:0] RV  = 32'h00000100;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        ins_valid;
    logic [31:0] ins;
    logic [31:0] pc_out;
`ifdef IF_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    if_fetch #(.WordSize(32), .ResetVector(RV), .BufDepth(BD)) dut (
        .clk(clk), .rstn(rstn),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
        .ins_valid(ins_valid), .ins(ins), .pc_out(pc_out)
`ifdef IF_MISALIGN_TRAP_EN
        , .misalign(misalign)
`endif
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] mq_addr [$];
    int          mq_due  [$];
    logic [31:0] got_pc  [$];
    logic        s_req, s_iv;
    logic [31:0] s_addr, s_ins, s_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h13579bdf;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: present the memory response, sample outputs, clock, update the memory model.
    task automatic step();
        logic        acc;
        logic [31:0] a;
        imem_rsp_valid = rstn && mq_due.size() > 0 && mq_due[0] <= cyc;
        imem_rsp_data  = imem_rsp_valid ? mem_word(mq_addr[0]) : 32'h0;
        #1;
        acc    = rstn && imem_req_valid && imem_req_ready;
        a      = imem_addr;
        s_req  = imem_req_valid;
        s_addr = imem_addr;
        s_iv   = ins_valid;
        s_ins  = ins;
        s_pc   = pc_out;
        if (rstn && ins_valid && !stall && !redirect) begin
            got_pc.push_back(pc_out);
            check("ins_word", ins, mem_word(pc_out));
        end
        @(posedge clk);
        if (imem_rsp_valid) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (acc) begin
            mq_addr.push_back(a);
            mq_due.push_back(cyc + lat);
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        redirect = 1'b0;
        stall = 1'b0;
        mq_addr.delete();
        mq_due.delete();
        step();
        step();
        check("rst_req_valid", {31'b0, s_req}, 32'h0);
        check("rst_ins_valid", {31'b0, s_iv}, 32'h0);
        check("rst_ins", s_ins, NOP);
        check("rst_pc_out", s_pc, 32'h0);
        check("rst_addr", s_addr, RV);
`ifdef IF_MISALIGN_TRAP_EN
        check("rst_misalign", {31'b0, misalign}, 32'h0);
`endif
        rstn = 1'b1;
        cyc = 0;
        got_pc.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(posedge clk);
        #1;
        // Streaming after reset with a 1-cycle memory
        lat = 1;
        do_reset();
        step();
        check("t1_c0_req", {31'b0, s_req}, 32'h1);
        check("t1_c0_addr", s_addr, 32'h100);
        check("t1_c0_iv", {31'b0, s_iv}, 32'h0);
        step();
        check("t1_c1_addr", s_addr, 32'h104);
        step();
        check("t1_c2_addr", s_addr, 32'h108);
        check("t1_c2_iv", {31'b0, s_iv}, 32'h1);
        check("t1_c2_pc", s_pc, 32'h100);
        step();
        check("t1_c3_addr", s_addr, 32'h10c);
        check("t1_c3_pc", s_pc, 32'h104);

        // Stall from the start: requests stop at BD in flight+buffered, head frozen
        do_reset();
        stall = 1'b1;
        repeat (4) step();
        step();
        check("t2_c4_req", {31'b0, s_req}, 32'h0);
        check("t2_c4_iv", {31'b0, s_iv}, 32'h1);
        check("t2_c4_pc", s_pc, 32'h100);
        step();
        check("t2_c5_req", {31'b0, s_req}, 32'h0);
        check("t2_c5_pc", s_pc, 32'h100);
        check("t2_c5_ins", s_ins, mem_word(32'h100));
        stall = 1'b0;
        for (int i = 0; i < 12; i++) begin
            stall = (i % 3) == 1;
            step();
        end
        stall = 1'b0;
        check("t2_count_ok", {31'b0, got_pc.size() >= 6}, 32'h1);
        for (int i = 0; i < 6; i++)
            check("t2_seq_pc", (i < got_pc.size()) ? got_pc[i] : 32'hdeadbeef, RV + 32'(4 * i));

        // Redirect with two requests in flight on a 3-cycle memory (also a mid-traffic reset)
        lat = 3;
        do_reset();
        step();
        redirect = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        step();
        check("t3_c2_req", {31'b0, s_req}, 32'h0);
        step();
        check("t3_c3_req", {31'b0, s_req}, 32'h0);
        step();
        check("t3_c4_req", {31'b0, s_req}, 32'h1);
        check("t3_c4_addr", s_addr, 32'h200);
        repeat (3) step();
        check("t3_c7_iv", {31'b0, s_iv}, 32'h0);
        step();
        check("t3_c8_iv", {31'b0, s_iv}, 32'h1);
        check("t3_c8_pc", s_pc, 32'h200);
        repeat (6) step();
        check("t3_first_pop", (got_pc.size() > 0) ? got_pc[0] : 32'hdeadbeef, 32'h200);

        // Redirect coinciding with a response under stall
        lat = 1;
        do_reset();
        stall = 1'b1;
        step();
        step();
        redirect = 1'b1;
        redirect_pc = 32'h300;
        step();
        redirect = 1'b0;
        check("t4_c2_iv", {31'b0, s_iv}, 32'h1);
        step();
        check("t4_c3_iv", {31'b0, s_iv}, 32'h0);
        check("t4_c3_ins", s_ins, NOP);
        check("t4_c3_pc_hold", s_pc, 32'h100);
        check("t4_c3_addr", s_addr, 32'h300);
        step();
        step();
        check("t4_c5_iv", {31'b0, s_iv}, 32'h1);
        check("t4_c5_pc", s_pc, 32'h300);
        stall = 1'b0;

        // PC wrap at the top of the address space
        do_reset();
        redirect = 1'b1;
        redirect_pc = 32'hfffffffc;
        step();
        redirect = 1'b0;
        step();
        check("t5_c1_addr", s_addr, 32'hfffffffc);
        step();
        check("t5_c2_addr", s_addr, 32'h0);
        step();
        check("t5_c3_pc", s_pc, 32'hfffffffc);
        step();
        check("t5_c4_pc", s_pc, 32'h0);

        // Misaligned redirect target
        do_reset();
        redirect = 1'b1;
        redirect_pc = 32'h20a;
        step();
        redirect = 1'b0;
        step();
`ifdef IF_MISALIGN_TRAP_EN
        check("t6_misalign", {31'b0, misalign}, 32'h1);
        check("t6_c1_req", {31'b0, s_req}, 32'h0);
        repeat (4) step();
        check("t6_halt_req", {31'b0, s_req}, 32'h0);
        check("t6_halt_iv", {31'b0, s_iv}, 32'h0);
        check("t6_misalign_sticky", {31'b0, misalign}, 32'h1);
        do_reset();
        step();
        check("t6_after_rst_req", {31'b0, s_req}, 32'h1);
        check("t6_after_rst_addr", s_addr, RV);
`else
        check("t6_c1_req", {31'b0, s_req}, 32'h1);
        check("t6_c1_addr", s_addr, 32'h208);
        repeat (2) step();
        check("t6_c3_pc", s_pc, 32'h208);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
